// File: rtl/rtc_bus_reader_pkg.sv
// Shared definitions for the RTC multiplexed-bus read engine: state encoding,
// default phase timings and the counter-load helper.
package rtc_bus_reader_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    ADDR = 3'd1,
    TURN = 3'd2,
    READ = 3'd3,
    REC  = 3'd4
  } state_t;

  localparam int DEF_N_ALE  = 4;
  localparam int DEF_N_TURN = 2;
  localparam int DEF_N_RD   = 6;
  localparam int DEF_N_REC  = 4;
  localparam int CNT_W      = 4;

  // The timer counts down to zero, so a phase of n cycles loads n-1.
  function automatic logic [CNT_W-1:0] phase_load(input int n);
    return CNT_W'(n - 1);
  endfunction

endpackage

// File: rtl/rtc_bus_reader_phase_timer.sv
// Loadable 4-bit down-counter; tc flags that the current phase is in its last cycle.
module phase_timer
  import rtc_bus_reader_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             tc
);

  logic [CNT_W-1:0] count_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= load_val;
    end else if (count_reg != '0) begin
      count_reg <= count_reg - 1'b1;
    end
  end

  assign tc = (count_reg == '0);

endmodule

// File: rtl/rtc_bus_reader.sv
// Issues one read cycle on a multiplexed address/data RTC bus: address latch,
// turnaround, read strobe and recovery, each phase timed by phase_timer.
module rtc_bus_reader
  import rtc_bus_reader_pkg::*;
#(
  parameter int N_ALE  = DEF_N_ALE,
  parameter int N_TURN = DEF_N_TURN,
  parameter int N_RD   = DEF_N_RD,
  parameter int N_REC  = DEF_N_REC
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] addr,
  input  logic [7:0] ad_in,
  output logic [7:0] ad_out,
  output logic       ad_oe,
  output logic       cs_n,
  output logic       ale,
  output logic       rd_n,
  output logic       wr_n,
  output logic [7:0] dato,
  output logic       busy,
  output logic       done
);

  state_t           state_reg;
  logic             timer_load;
  logic [CNT_W-1:0] timer_val;
  logic             timer_tc;

  phase_timer u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (timer_load),
    .load_val (timer_val),
    .tc       (timer_tc)
  );

  // Reload the timer on every state entry with the length of the phase being entered.
  always_comb begin
    timer_load = 1'b0;
    timer_val  = '0;
    case (state_reg)
      IDLE: if (start) begin
        timer_load = 1'b1;
        timer_val  = phase_load(N_ALE);
      end
      ADDR: if (timer_tc) begin
        timer_load = 1'b1;
        timer_val  = phase_load(N_TURN);
      end
      TURN: if (timer_tc) begin
        timer_load = 1'b1;
        timer_val  = phase_load(N_RD);
      end
      READ: if (timer_tc) begin
        timer_load = 1'b1;
        timer_val  = phase_load(N_REC);
      end
      REC: if (timer_tc) begin
        timer_load = 1'b1;
        timer_val  = start ? phase_load(N_ALE) : '0;
      end
      default: ;
    endcase
  end

  // Outputs are registered and set for the state being entered, so strobes never glitch.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
      cs_n      <= 1'b1;
      ale       <= 1'b0;
      rd_n      <= 1'b1;
      wr_n      <= 1'b1;
      ad_oe     <= 1'b0;
      ad_out    <= 8'h00;
      dato      <= 8'h00;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      wr_n <= 1'b1;
      done <= 1'b0;
      case (state_reg)
        IDLE: if (start) begin
          state_reg <= ADDR;
          cs_n      <= 1'b0;
          ale       <= 1'b1;
          ad_oe     <= 1'b1;
          ad_out    <= addr;
          busy      <= 1'b1;
        end
        ADDR: if (timer_tc) begin
          state_reg <= TURN;
          ale       <= 1'b0;
          ad_oe     <= 1'b0;
          ad_out    <= 8'h00;
        end
        TURN: if (timer_tc) begin
          state_reg <= READ;
          rd_n      <= 1'b0;
        end
        READ: if (timer_tc) begin
          state_reg <= REC;
          rd_n      <= 1'b1;
          cs_n      <= 1'b1;
          dato      <= ad_in;
        end
        REC: if (timer_tc) begin
          done <= 1'b1;
          // The exit edge doubles as the IDLE accept edge so held start runs back-to-back.
          if (start) begin
            state_reg <= ADDR;
            cs_n      <= 1'b0;
            ale       <= 1'b1;
            ad_oe     <= 1'b1;
            ad_out    <= addr;
          end else begin
            state_reg <= IDLE;
            busy      <= 1'b0;
          end
        end
        default: begin
          state_reg <= IDLE;
          cs_n      <= 1'b1;
          ale       <= 1'b0;
          rd_n      <= 1'b1;
          ad_oe     <= 1'b0;
          ad_out    <= 8'h00;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rtc_bus_reader.sv
// Directed bench for rtc_bus_reader: default-timing instance driven from a phase
// table, plus a 1-cycle-per-phase instance and hand-written multi-cycle sequences.
module tb_rtc_bus_reader;

  logic       clk;
  logic       reset;
  logic       start, c_start;
  logic [7:0] addr, c_addr;
  logic [7:0] ad_in, c_ad_in;
  logic [7:0] ad_out, c_ad_out;
  logic       ad_oe, c_ad_oe;
  logic       cs_n, c_cs_n;
  logic       ale, c_ale;
  logic       rd_n, c_rd_n;
  logic       wr_n, c_wr_n;
  logic [7:0] dato, c_dato;
  logic       busy, c_busy;
  logic       done, c_done;

  int tests = 0;
  int fails = 0;

  rtc_bus_reader u_dut (
    .clk(clk), .reset(reset), .start(start), .addr(addr), .ad_in(ad_in),
    .ad_out(ad_out), .ad_oe(ad_oe), .cs_n(cs_n), .ale(ale), .rd_n(rd_n),
    .wr_n(wr_n), .dato(dato), .busy(busy), .done(done)
  );

  rtc_bus_reader #(.N_ALE(1), .N_TURN(1), .N_RD(1), .N_REC(1)) u_corner (
    .clk(clk), .reset(reset), .start(c_start), .addr(c_addr), .ad_in(c_ad_in),
    .ad_out(c_ad_out), .ad_oe(c_ad_oe), .cs_n(c_cs_n), .ale(c_ale), .rd_n(c_rd_n),
    .wr_n(c_wr_n), .dato(c_dato), .busy(c_busy), .done(c_done)
  );

  always #5 clk = ~clk;

  // {cs_n, ale, rd_n, wr_n, ad_oe, busy, done, ad_out, dato}
  logic [22:0] obs_vec, c_obs_vec;
  assign obs_vec   = {cs_n, ale, rd_n, wr_n, ad_oe, busy, done, ad_out, dato};
  assign c_obs_vec = {c_cs_n, c_ale, c_rd_n, c_wr_n, c_ad_oe, c_busy, c_done, c_ad_out, c_dato};

  typedef struct packed {
    logic [7:0] j_lo;
    logic [7:0] j_hi;
    logic       cs_n;
    logic       ale;
    logic       rd_n;
    logic       ad_oe;
    logic       addr_on;
    logic       busy;
    logic       done;
  } row_t;

  row_t tbl [6];

  // Bus contention: address drive and read strobe never overlap, no write strobe ever.
  always @(negedge clk) begin
    tests++;
    if ((ad_oe && !rd_n) || !wr_n || (c_ad_oe && !c_rd_n) || !c_wr_n) begin
      fails++;
      $display("FAIL contention: ad_oe=%b rd_n=%b wr_n=%b c_ad_oe=%b c_rd_n=%b c_wr_n=%b required no overlap and wr_n=1",
               ad_oe, rd_n, wr_n, c_ad_oe, c_rd_n, c_wr_n);
    end
  end

  task automatic check(input string name, input logic [22:0] act, input logic [22:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  // One read on the default instance; j counts edges since the accept edge.
  // If rej_j >= 0, a stray start with addr 30 is raised for one cycle at that point.
  task automatic run_read(input logic [7:0] a, input logic [7:0] d,
                          input logic [7:0] prev, input int rej_j);
    logic [22:0] exp;
    @(negedge clk);
    start = 1'b1;
    addr  = a;
    ad_in = 8'hFF;
    for (int j = 0; j <= 20; j++) begin
      @(negedge clk);
      exp = {1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, prev};
      for (int r = 0; r < 6; r++) begin
        if (j >= int'(tbl[r].j_lo) && j <= int'(tbl[r].j_hi))
          exp = {tbl[r].cs_n, tbl[r].ale, tbl[r].rd_n, 1'b1, tbl[r].ad_oe,
                 tbl[r].busy, tbl[r].done, (tbl[r].addr_on ? a : 8'h00),
                 (j >= 12 ? d : prev)};
      end
      check($sformatf("read%02h_j%0d", a, j), obs_vec, exp);
      start = (j == rej_j);
      addr  = (j == rej_j) ? 8'h30 : a;
      ad_in = (j == 11) ? d : 8'hFF;
    end
    $display("[TB] read addr=%02h ad_in=%02h reject_at=%0d -> dato=%02h", a, d, rej_j, dato);
  endtask

  initial begin
    int          csn_high;
    int          done_pos [$];
    logic [22:0] cexp [6];

    tbl[0] = '{j_lo: 8'd0,  j_hi: 8'd3,  cs_n: 1'b0, ale: 1'b1, rd_n: 1'b1, ad_oe: 1'b1, addr_on: 1'b1, busy: 1'b1, done: 1'b0};
    tbl[1] = '{j_lo: 8'd4,  j_hi: 8'd5,  cs_n: 1'b0, ale: 1'b0, rd_n: 1'b1, ad_oe: 1'b0, addr_on: 1'b0, busy: 1'b1, done: 1'b0};
    tbl[2] = '{j_lo: 8'd6,  j_hi: 8'd11, cs_n: 1'b0, ale: 1'b0, rd_n: 1'b0, ad_oe: 1'b0, addr_on: 1'b0, busy: 1'b1, done: 1'b0};
    tbl[3] = '{j_lo: 8'd12, j_hi: 8'd15, cs_n: 1'b1, ale: 1'b0, rd_n: 1'b1, ad_oe: 1'b0, addr_on: 1'b0, busy: 1'b1, done: 1'b0};
    tbl[4] = '{j_lo: 8'd16, j_hi: 8'd16, cs_n: 1'b1, ale: 1'b0, rd_n: 1'b1, ad_oe: 1'b0, addr_on: 1'b0, busy: 1'b0, done: 1'b1};
    tbl[5] = '{j_lo: 8'd17, j_hi: 8'd20, cs_n: 1'b1, ale: 1'b0, rd_n: 1'b1, ad_oe: 1'b0, addr_on: 1'b0, busy: 1'b0, done: 1'b0};

    clk = 1'b0; reset = 1'b1;
    start = 1'b0; addr = 8'h00; ad_in = 8'h00;
    c_start = 1'b0; c_addr = 8'h00; c_ad_in = 8'h00;

    // Reset state, during and after reset
    repeat (2) @(negedge clk);
    check("reset_hold", obs_vec, {7'b1011000, 8'h00, 8'h00});
    check("reset_hold_corner", c_obs_vec, {7'b1011000, 8'h00, 8'h00});
    reset = 1'b0;
    @(negedge clk);
    check("reset_release", obs_vec, {7'b1011000, 8'h00, 8'h00});
    $display("[TB] reset checked");

    // Basic read, then a read with a rejected start during TURN
    run_read(8'h21, 8'hA5, 8'h00, -1);
    run_read(8'h42, 8'h3C, 8'hA5, 4);

    // Back-to-back reads with start held high
    @(negedge clk);
    start = 1'b1; addr = 8'h00; ad_in = 8'hFF;
    csn_high = 0;
    for (int j = 0; j <= 35; j++) begin
      @(negedge clk);
      if (done) done_pos.push_back(j);
      if (j <= 15 && cs_n) csn_high++;
      if (j == 12) check("b2b_dato1", {15'h0, dato}, {15'h0, 8'h11});
      if (j == 16) check("b2b_reaccept", obs_vec, {7'b0111111, 8'h01, 8'h11});
      if (j == 28) check("b2b_dato2", {15'h0, dato}, {15'h0, 8'h22});
      if (j == 32) check("b2b_end", obs_vec, {7'b1011001, 8'h00, 8'h22});
      addr  = 8'h01;
      start = (j < 16);
      ad_in = (j == 11) ? 8'h11 : (j == 27) ? 8'h22 : 8'hFF;
    end
    check("b2b_csn_gap", 23'(csn_high), 23'd4);
    check("b2b_done_count", 23'(done_pos.size()), 23'd2);
    if (done_pos.size() == 2)
      check("b2b_done_pos", {7'h0, 8'(done_pos[0]), 8'(done_pos[1])}, {7'h0, 8'd16, 8'd32});
    $display("[TB] back-to-back reads 00/01 -> dato=%02h done_count=%0d", dato, done_pos.size());

    // Mid-read reset
    run_read(8'h44, 8'h5A, 8'h22, -1);
    @(negedge clk);
    start = 1'b1; addr = 8'h55; ad_in = 8'hFF;
    for (int j = 0; j <= 8; j++) begin
      @(negedge clk);
      start = 1'b0;
    end
    check("midrst_in_read", {22'h0, rd_n}, 23'h0);
    reset = 1'b1;
    #1;
    check("midrst_async", obs_vec, {7'b1011000, 8'h00, 8'h00});
    @(negedge clk);
    check("midrst_hold", obs_vec, {7'b1011000, 8'h00, 8'h00});
    reset = 1'b0;
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      check($sformatf("midrst_idle_%0d", j), obs_vec, {7'b1011000, 8'h00, 8'h00});
    end
    $display("[TB] mid-read reset -> dato=%02h busy=%b", dato, busy);
    run_read(8'h77, 8'h99, 8'h00, -1);

    // Single-cycle phases on the corner instance
    cexp[0] = {7'b0111110, 8'hC3, 8'h00};
    cexp[1] = {7'b0011010, 8'h00, 8'h00};
    cexp[2] = {7'b0001010, 8'h00, 8'h00};
    cexp[3] = {7'b1011010, 8'h00, 8'hE7};
    cexp[4] = {7'b1011001, 8'h00, 8'hE7};
    cexp[5] = {7'b1011000, 8'h00, 8'hE7};
    @(negedge clk);
    c_start = 1'b1; c_addr = 8'hC3; c_ad_in = 8'hFF;
    for (int j = 0; j < 6; j++) begin
      @(negedge clk);
      check($sformatf("corner_j%0d", j), c_obs_vec, cexp[j]);
      c_start = 1'b0;
      c_ad_in = (j == 2) ? 8'hE7 : 8'hFF;
    end
    $display("[TB] corner read addr=C3 ad_in=E7 -> dato=%02h", c_dato);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/rtc_bus_reader.md
RTC_BUS_READER -- requirements
Module: rtc_bus_reader

Interface
REQ-001 Parameter N_ALE, default 4, cycles ALE stays high with the address driven (range 1..15).
REQ-002 Parameter N_TURN, default 2, bus turnaround cycles between address and read strobe (range 1..15).
REQ-003 Parameter N_RD, default 6, cycles RD_n stays low (range 1..15).
REQ-004 Parameter N_REC, default 4, recovery cycles with all strobes inactive (range 1..15).
REQ-005 clk  in  1  single system clock; all state changes on its rising edge.
REQ-006 reset  in  1  asynchronous, active-high reset.
REQ-007 start  in  1  request one read cycle; sampled only in IDLE.
REQ-008 addr  in  8  RTC register address; captured when start is accepted.
REQ-009 ad_in  in  8  data sampled from the multiplexed AD bus.
REQ-010 ad_out  out  8  address driven onto the AD bus.
REQ-011 ad_oe  out  1  AD bus output enable (1 = drive ad_out).
REQ-012 cs_n, ale, rd_n, wr_n  out  1 each  RTC chip select, address latch, read and write strobes.
REQ-013 dato  out  8  last data read, held until the next read completes.
REQ-014 busy  out  1  high whenever state is not IDLE.
REQ-015 done  out  1  one-cycle pulse when a read completes.

Function
REQ-016 The FSM SHALL have the states IDLE, ADDR, TURN, READ and REC, driven by one 4-bit down-counter loaded on each state entry.
REQ-017 In IDLE with start=1 at edge k, the block SHALL capture addr and enter ADDR at edge k.
REQ-018 In ADDR: cs_n=0, ale=1, ad_oe=1 and ad_out=captured addr, for exactly N_ALE cycles, then TURN.
REQ-019 In TURN: cs_n=0, ale=0, ad_oe=0, rd_n=1, for N_TURN cycles, then READ.
REQ-020 In READ: cs_n=0 and rd_n=0 for N_RD cycles; dato SHALL load ad_in at the edge leaving READ.
REQ-021 In REC: cs_n=1, rd_n=1, ale=0, ad_oe=0, for N_REC cycles, then IDLE.
REQ-022 done SHALL be high for exactly the one cycle after leaving REC, i.e. at edge k+N_ALE+N_TURN+N_RD+N_REC (k+16 with defaults).
REQ-023 Start issued while busy=1 SHALL be ignored and not queued; start held high in IDLE SHALL start back-to-back reads, done coinciding with the next accept.
REQ-024 wr_n SHALL be constant 1; no state SHALL drive ad_oe and rd_n=0 simultaneously.
REQ-025 All outputs SHALL be registered (glitch-free strobes); ad_out SHALL be 0 outside ADDR.

Reset
REQ-026 While reset=1, asynchronously: state=IDLE, counter=0, cs_n=1, ale=0, rd_n=1, wr_n=1, ad_oe=0, ad_out=0, dato=0, busy=0, done=0.
REQ-027 A reset asserted mid-operation SHALL abort the cycle without updating dato and without pulsing done; start is accepted from the first edge after reset is released.

Structure
REQ-028 A shared package SHALL hold the state encoding constants (IDLE=0, ADDR=1, TURN=2, READ=3, REC=4) and the default timing constants.
REQ-029 The loadable 4-bit down-counter with terminal-count flag SHALL be the sub-module phase_timer; everything else SHALL live in rtc_bus_reader.

Verification
REQ-030 Basic read, defaults: start pulse with addr=8'h21, ad_in=8'hA5 during READ -> ale high 4 cycles with ad_out=21, rd_n low 6 cycles, dato=A5, done at start edge+16.
REQ-031 Busy rejection: second start with addr=8'h30 at cycle 5 of a read -> ignored; only one done; dato holds the first read's value.
REQ-032 Back-to-back: start held high 2 reads (addr 8'h00 then 8'h01, ad_in 8'h11 then 8'h22) -> dato 11 then 22; two done pulses 16 cycles apart; cs_n high for 4 cycles between reads.
REQ-033 Mid-read reset: reset asserted in READ with dato=8'h5A from a prior read -> immediate idle outputs, dato=0, no done; next read completes normally.
REQ-034 Parameter corner: N_ALE=N_TURN=N_RD=N_REC=1 -> each phase lasts 1 cycle; done at start edge+4; ad_oe and rd_n=0 never overlap.
REQ-035 Bus contention check (all scenarios): assertion that ad_oe=1 implies rd_n=1, and wr_n=1 always.
